// File: rtl/sensor_sample_buffer.sv
// sensor_sample_buffer
//   Captures sensor words into a local buffer while sampling is enabled, raises an
//   interrupt once the buffer is full, and serves registered random-access reads.
//
//   Optional feature: define SCTRL_DROP_CNT_EN to add a saturating 16-bit counter of
//   samples that arrive while the buffer is full (driven on sctrl_drop_o).
//
// Ports
//   clk            system clock
//   rst            synchronous active-high reset
//   sctrl_en_i     sampling enable
//   sctrl_clear_i  clear pulse: empties buffer, drops interrupt
//   sctrl_addr_i   read index
//   sctrl_out_o    registered read data (1-cycle latency)
//   sctrl_count_o  words currently held, 0..DEPTH
//   sctrl_int_o    buffer-full interrupt
//   sensor_ready_i sensor word valid this cycle
//   sensor_out_i   sensor data
//   sensor_en_o    request sensor to produce samples
//   sctrl_drop_o   dropped-sample count (SCTRL_DROP_CNT_EN only)
module sensor_sample_buffer #(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sctrl_en_i,
   input  logic              sctrl_clear_i,
   input  logic [ADDR_W-1:0] sctrl_addr_i,
   output logic [31:0]       sctrl_out_o,
   output logic [ADDR_W:0]   sctrl_count_o,
   output logic              sctrl_int_o,
   input  logic              sensor_ready_i,
   input  logic [31:0]       sensor_out_i,
`ifdef SCTRL_DROP_CNT_EN
   output logic [15:0]       sctrl_drop_o,
`endif
   output logic              sensor_en_o
);

   typedef enum logic [1:0] {StIdle, StSample, StFull} state_e;

   // Count value just before the filling write.
   localparam logic [ADDR_W:0]   CountLast = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   CountOne  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] WptrOne   = ADDR_W'(1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [31:0]       rdata_q;
   logic              wr_en;

   logic [31:0] mem_q [DEPTH];

   always_comb begin
      state_d = state_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      if (sctrl_clear_i) begin
         // Clear wins over a concurrent sample, which is discarded.
         state_d = StIdle;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (sctrl_en_i) state_d = StSample;
            end
            StSample: begin
               if (!sctrl_en_i) state_d = StIdle;
               // A sample arriving as enable falls is still captured.
               if (sensor_ready_i) begin
                  wr_en   = 1'b1;
                  wptr_d  = wptr_q + WptrOne;  // wraps to 0 on the filling write
                  count_d = count_q + CountOne;
                  if (count_q == CountLast) state_d = StFull;
               end
            end
            StFull: begin
               // Held until clear; enable is ignored.
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         wptr_q  <= '0;
         count_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
         rdata_q <= mem_q[sctrl_addr_i];  // read-before-write on index collision
      end
   end

   // Buffer storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         mem_q[wptr_q] <= sensor_out_i;
      end
   end

`ifdef SCTRL_DROP_CNT_EN
   logic [15:0] drop_q, drop_d;

   always_comb begin
      drop_d = drop_q;
      if (sctrl_clear_i) begin
         drop_d = '0;
      end else if (state_q == StFull && sensor_ready_i && drop_q != 16'hFFFF) begin
         drop_d = drop_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_q <= '0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign sctrl_drop_o = drop_q;
`endif

   assign sctrl_out_o   = rdata_q;
   assign sctrl_count_o = count_q;
   assign sctrl_int_o   = (state_q == StFull);
   assign sensor_en_o   = (state_q == StSample);

endmodule

// File: tb/tb_sensor_sample_buffer.sv
module tb_sensor_sample_buffer;

   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 6;

   logic              clk;
   logic              rst;
   logic              sctrl_en_i;
   logic              sctrl_clear_i;
   logic [ADDR_W-1:0] sctrl_addr_i;
   logic [31:0]       sctrl_out_o;
   logic [ADDR_W:0]   sctrl_count_o;
   logic              sctrl_int_o;
   logic              sensor_ready_i;
   logic [31:0]       sensor_out_i;
   logic              sensor_en_o;
`ifdef SCTRL_DROP_CNT_EN
   logic [15:0]       sctrl_drop_o;
`endif

   int unsigned n_total;
   int unsigned n_pass;
   logic [31:0] exp_q[$];

   sensor_sample_buffer #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .sctrl_en_i     (sctrl_en_i),
      .sctrl_clear_i  (sctrl_clear_i),
      .sctrl_addr_i   (sctrl_addr_i),
      .sctrl_out_o    (sctrl_out_o),
      .sctrl_count_o  (sctrl_count_o),
      .sctrl_int_o    (sctrl_int_o),
      .sensor_ready_i (sensor_ready_i),
      .sensor_out_i   (sensor_out_i),
`ifdef SCTRL_DROP_CNT_EN
      .sctrl_drop_o   (sctrl_drop_o),
`endif
      .sensor_en_o    (sensor_en_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   // Read one index; expectation comes from the scoreboard queue.
   task automatic sb_read(input string tag, input int unsigned idx);
      logic [31:0] e;
      sctrl_addr_i = ADDR_W'(idx);
      step();
      if (exp_q.size() == 0) begin
         n_total++;
         $error("FAIL %s: scoreboard empty at index %0d, got 0x%08h", tag, idx, sctrl_out_o);
      end else begin
         e = exp_q.pop_front();
         chk(tag, sctrl_out_o, e);
      end
   endtask

   task automatic pulse(input logic [31:0] d);
      sensor_ready_i = 1'b1;
      sensor_out_i   = d;
      step();
      sensor_ready_i = 1'b0;
   endtask

   initial begin
      n_total        = 0;
      n_pass         = 0;
      rst            = 1'b1;
      sctrl_en_i     = 1'b0;
      sctrl_clear_i  = 1'b0;
      sctrl_addr_i   = '0;
      sensor_ready_i = 1'b0;
      sensor_out_i   = '0;

      // Reset held for two cycles.
      step();
      step();
      chk("rst_sensor_en", 32'(sensor_en_o), 32'd0);
      chk("rst_int", 32'(sctrl_int_o), 32'd0);
      chk("rst_out", sctrl_out_o, 32'd0);
      chk("rst_count", 32'(sctrl_count_o), 32'd0);
`ifdef SCTRL_DROP_CNT_EN
      chk("rst_drop", 32'(sctrl_drop_o), 32'd0);
`endif
      rst = 1'b0;

      // Fill the whole buffer.
      sctrl_en_i = 1'b1;
      step();
      chk("fill_sensor_en", 32'(sensor_en_o), 32'd1);
      chk("fill_count0", 32'(sctrl_count_o), 32'd0);
      for (int i = 0; i < 64; i++) begin
         exp_q.push_back(32'h1000 + 32'(i));
         if (i == 63) chk("fill_int_before_last", 32'(sctrl_int_o), 32'd0);
         pulse(32'h1000 + 32'(i));
      end
      chk("full_int", 32'(sctrl_int_o), 32'd1);
      chk("full_sensor_en", 32'(sensor_en_o), 32'd0);
      chk("full_count", 32'(sctrl_count_o), 32'd64);
      sctrl_addr_i = 6'd5;
      step();
      chk("full_rd5", sctrl_out_o, 32'h0000_1005);
      for (int i = 0; i < 64; i++) sb_read("fill_rd", i);

      // Sample in FULL is ignored; enable dropping does not leave FULL.
      sctrl_en_i = 1'b0;
      pulse(32'hFFFF_0000);
      chk("full_ignore_en", 32'(sctrl_int_o), 32'd1);
      chk("full_ignore_cnt", 32'(sctrl_count_o), 32'd64);

      // Clear from FULL, then refill from index 0.
      sctrl_en_i    = 1'b1;
      sctrl_clear_i = 1'b1;
      step();
      sctrl_clear_i = 1'b0;
      chk("clr_int", 32'(sctrl_int_o), 32'd0);
      chk("clr_count", 32'(sctrl_count_o), 32'd0);
      chk("clr_idle", 32'(sensor_en_o), 32'd0);
      step();
      chk("clr_resample", 32'(sensor_en_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(32'hA0 + 32'(i));
         pulse(32'hA0 + 32'(i));
      end
      chk("refill_count", 32'(sctrl_count_o), 32'd4);
      for (int i = 0; i < 4; i++) sb_read("refill_rd", i);
      // Index 4 was untouched since the first fill.
      exp_q.push_back(32'h1004);
      sb_read("refill_stale4", 4);

      // Pause / resume.
      sctrl_en_i    = 1'b0;
      sctrl_clear_i = 1'b1;
      step();
      sctrl_clear_i = 1'b0;
      sctrl_en_i    = 1'b1;
      step();
      for (int i = 0; i < 10; i++) begin
         // Last sample coincides with enable falling and must still land.
         if (i == 9) sctrl_en_i = 1'b0;
         pulse(32'h2000 + 32'(i));
      end
      chk("pause_count10", 32'(sctrl_count_o), 32'd10);
      chk("pause_idle", 32'(sensor_en_o), 32'd0);
      for (int i = 0; i < 5; i++) pulse(32'hDEAD);
      chk("pause_ignored", 32'(sctrl_count_o), 32'd10);
      sctrl_en_i = 1'b1;
      step();
      pulse(32'h0000_BEEF);
      chk("resume_count", 32'(sctrl_count_o), 32'd11);
      exp_q.push_back(32'h0000_BEEF);
      sb_read("resume_rd10", 10);
      exp_q.push_back(32'h2009);
      sb_read("pause_edge_rd9", 9);
      exp_q.push_back(32'h100B);
      sb_read("stale_rd11", 11);

      // Same-index read/write returns old data; clear discards a concurrent sample.
      sctrl_clear_i = 1'b1;
      step();
      sctrl_clear_i = 1'b0;
      step();
      pulse(32'h3000);
      pulse(32'h3001);
      sctrl_addr_i = 6'd2;
      pulse(32'h3002);
      chk("rw_collide_old", sctrl_out_o, 32'h2002);
      chk("coll_count3", 32'(sctrl_count_o), 32'd3);
      sensor_ready_i = 1'b1;
      sensor_out_i   = 32'h5555_5555;
      sctrl_clear_i  = 1'b1;
      step();
      sensor_ready_i = 1'b0;
      sctrl_clear_i  = 1'b0;
      chk("coll_count0", 32'(sctrl_count_o), 32'd0);
      chk("coll_idle", 32'(sensor_en_o), 32'd0);
      exp_q.push_back(32'h2003);
      sb_read("coll_rd3", 3);
      exp_q.push_back(32'h3002);
      sb_read("coll_rd2", 2);

`ifdef SCTRL_DROP_CNT_EN
      // Drop counter: state is SAMPLE with count 0 here.
      for (int i = 0; i < 64; i++) pulse(32'(i));
      chk("drop_full", 32'(sctrl_int_o), 32'd1);
      chk("drop_zero", 32'(sctrl_drop_o), 32'd0);
      for (int i = 0; i < 3; i++) pulse(32'h0);
      chk("drop_3", 32'(sctrl_drop_o), 32'd3);
      sensor_ready_i = 1'b1;
      sctrl_clear_i  = 1'b1;
      step();
      sensor_ready_i = 1'b0;
      sctrl_clear_i  = 1'b0;
      chk("drop_clr", 32'(sctrl_drop_o), 32'd0);
      step();
      for (int i = 0; i < 64; i++) pulse(32'(i));
      sensor_ready_i = 1'b1;
      for (int i = 0; i < 70000; i++) step();
      sensor_ready_i = 1'b0;
      chk("drop_sat", 32'(sctrl_drop_o), 32'h0000_FFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
